bitfile_loader: RTL and testbench
=================================

// Module: bitfile_loader
// PURPOSE
//  - Serial configuration loader for the fabric Controller: receives a framed bit stream,
//    checks it, and drives the parallel bitfile words that set the per-cell Control_signals.
//  - Frame: sync byte, NUM_WORDS data bytes, XOR checksum byte. Each byte is sent MSB first.
//  - BITFILE_OUT changes only on a good frame, and always atomically. A bad or aborted frame
//    leaves the active configuration unchanged.
// PARAMETERS
//  NUM_WORDS  4      number of 8-bit bitfile words (one per Controller instance)
//  SYNC_BYTE  8'hA5  required first byte of every frame
//  TIMEOUT    255    idle cycles (no accepted bit) allowed mid-frame before error; >=1
// PORTS
//  CLK          in   1             system clock, rising edge
//  RST_N        in   1             synchronous active-low reset
//  CFG_START    in   1             1-cycle pulse: begin (or restart) a frame
//  CFG_BIT      in   1             serial data bit
//  CFG_VALID    in   1             CFG_BIT valid this cycle
//  CFG_READY    out  1             loader accepts a bit this cycle
//  BITFILE_OUT  out  8*NUM_WORDS   active config; word k at [8k+7:8k]; first data byte = word 0
//  CFG_DONE     out  1             1-cycle pulse: new config committed
//  CFG_ERR      out  1             sticky error flag
//  BUSY         out  1             frame in progress (state != IDLE/ERROR)
// BEHAVIOUR
//  - Reset (RST_N=0 at posedge): state=IDLE; BITFILE_OUT=0; CFG_DONE=0; CFG_ERR=0;
//    counters and shadow register=0.
//  - A bit is accepted only when CFG_VALID && CFG_READY.
//  - CFG_READY is 1 only in states SYNC, LOAD and CHECK. It is a combinational decode of the
//    state register.
//  - Byte assembly:
//    - 8-bit shift register: sh <= {sh[6:0],CFG_BIT}.
//    - 3-bit bit counter; it wraps 7->0 on the 8th accepted bit, which completes the byte.
//    - The byte is evaluated using the completed value {sh[6:0],CFG_BIT}.
//  - State transitions:
//    - IDLE: CFG_START -> SYNC. Clears bit/byte counters, XOR accumulator and timeout counter.
//      CFG_ERR is cleared.
//    - SYNC: on byte complete, byte==SYNC_BYTE -> LOAD; otherwise -> ERROR.
//    - LOAD: on byte complete, byte is stored to shadow word[byte_cnt] and xor ^= byte.
//      byte_cnt==NUM_WORDS-1 -> CHECK; otherwise byte_cnt++.
//    - CHECK: on byte complete, byte==xor -> COMMIT; otherwise -> ERROR.
//    - COMMIT: one cycle. At the next edge BITFILE_OUT<=shadow, CFG_DONE<=1, -> IDLE.
//      CFG_DONE is high the single cycle after COMMIT. Last checksum bit to CFG_DONE = 2 cycles.
//    - ERROR: CFG_ERR=1 and held. BITFILE_OUT unchanged. CFG_START -> SYNC (clears CFG_ERR);
//      otherwise stay in ERROR.
//  - Timeout: in SYNC/LOAD/CHECK, a counter increments on every cycle with no accepted bit and
//    clears on an accepted bit. Reaching TIMEOUT -> ERROR.
//  - CFG_START while in SYNC/LOAD/CHECK: abort. Go to SYNC, clear counters, xor and shadow.
//    Any bit presented in that same cycle is ignored. CFG_START has priority over bit
//    acceptance and over timeout.
//  - CFG_START in COMMIT: the commit still completes. The pulse is not lost; it is taken as the
//    next frame start, so the next state is SYNC and CFG_DONE still pulses.
//  - Reset mid-frame: abort. BITFILE_OUT returns to 0.
//  - Widths: byte_cnt is $clog2(NUM_WORDS) bits (minimum 1). The timeout counter is
//    $clog2(TIMEOUT+1) bits and saturates; it never wraps.
// STRUCTURE
//  - Shared package cfg_pkg holds:
//    - state encoding constants LD_IDLE, LD_SYNC, LD_LOAD, LD_CHECK, LD_COMMIT, LD_ERROR
//      (3 bits);
//    - CFG_WORD_W=8;
//    - default SYNC_BYTE.
//  - One sub-module: cfg_byte_shifter. It holds the shift register plus bit counter, takes
//    shift_en and clr, and outputs byte_done and the completed byte. The FSM, counters and
//    shadow register stay in the top level.
// TESTING
//  1. Good frame A5,EE,00,FF,12,03 with VALID held high:
//     - BITFILE_OUT=32'h12FF00EE;
//     - CFG_DONE is a single pulse 2 cycles after the last bit;
//     - BUSY drops; CFG_ERR=0.
//  2. Bad checksum (A5,EE,00,FF,12,04) after test 1:
//     - CFG_ERR=1;
//     - BITFILE_OUT remains 32'h12FF00EE; no CFG_DONE.
//  3. Bad sync byte 5A:
//     - ERROR after the 8th bit;
//     - CFG_READY=0 in ERROR;
//     - the next CFG_START clears CFG_ERR.
//  4. CFG_VALID dropped for 255 cycles mid-LOAD:
//     - ERROR on timeout;
//     - a 254-cycle gap followed by the remaining bits still commits.
//  5. CFG_START mid-LOAD (after A5,EE), then a full frame A5,01,02,03,04,04:
//     - BITFILE_OUT=32'h04030201.
//  6. RST_N=0 for one cycle mid-CHECK:
//     - all outputs 0, state IDLE;
//     - CFG_VALID bits are ignored until CFG_START.

Source files
------------

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared state encoding and constants for the bitfile loader
package cfg_pkg;
  localparam int CFG_WORD_W = 8;
  localparam logic [CFG_WORD_W-1:0] DEF_SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_SYNC   = 3'd1,
    LD_LOAD   = 3'd2,
    LD_CHECK  = 3'd3,
    LD_COMMIT = 3'd4,
    LD_ERROR  = 3'd5
  } ld_state_t;
endpackage

// File: rtl/cfg_byte_shifter.sv
// cfg_byte_shifter: MSB-first serial-to-byte assembler with 8-bit completion strobe
import cfg_pkg::*;
module cfg_byte_shifter (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic                  clr,
  input  logic                  bit_in,
  output logic                  byte_done,
  output logic [CFG_WORD_W-1:0] byte_val
);
  logic [CFG_WORD_W-2:0] sh;
  logic [2:0] cnt;
  assign byte_done = shift_en && cnt == 3'd7;
  assign byte_val = {sh, bit_in};
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sh <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sh <= byte_val[CFG_WORD_W-2:0];
      cnt <= cnt + 3'd1;
    end
  end
endmodule

// File: rtl/bitfile_loader.sv
// bitfile_loader: framed serial config loader; commits the shadow bitfile only on a good checksum
import cfg_pkg::*;
module bitfile_loader #(
  parameter int NUM_WORDS = 4,
  parameter logic [CFG_WORD_W-1:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_start,
  input  logic                            cfg_bit,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  output logic [CFG_WORD_W*NUM_WORDS-1:0] bitfile_out,
  output logic                            cfg_done,
  output logic                            cfg_err,
  output logic                            busy
);
  localparam int BCW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  ld_state_t state, state_nx;
  logic [BCW-1:0] byte_cnt;
  logic [TW-1:0] to_cnt;
  logic [CFG_WORD_W-1:0] xor_acc, byte_val;
  logic [CFG_WORD_W*NUM_WORDS-1:0] shadow;
  logic accept, byte_done, timed_out;
  assign cfg_ready = state == LD_SYNC || state == LD_LOAD || state == LD_CHECK;
  assign busy = state != LD_IDLE && state != LD_ERROR;
  // a start pulse discards any bit presented alongside it
  assign accept = cfg_valid && cfg_ready && !cfg_start;
  assign timed_out = !accept && to_cnt >= TW'(TIMEOUT - 1);
  cfg_byte_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .clr      (cfg_start),
    .bit_in   (cfg_bit),
    .byte_done(byte_done),
    .byte_val (byte_val)
  );
  always_comb begin
    state_nx = state;
    case (state)
      LD_IDLE, LD_ERROR: state_nx = cfg_start ? LD_SYNC : state;
      LD_SYNC, LD_LOAD, LD_CHECK: begin
        if (cfg_start) state_nx = LD_SYNC;
        else if (byte_done && state == LD_SYNC) state_nx = byte_val == SYNC_BYTE ? LD_LOAD : LD_ERROR;
        else if (byte_done && state == LD_LOAD) state_nx = byte_cnt == BCW'(NUM_WORDS - 1) ? LD_CHECK : LD_LOAD;
        else if (byte_done) state_nx = byte_val == xor_acc ? LD_COMMIT : LD_ERROR;
        else if (timed_out) state_nx = LD_ERROR;
      end
      LD_COMMIT: state_nx = cfg_start ? LD_SYNC : LD_IDLE;
      default: state_nx = LD_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LD_IDLE;
      bitfile_out <= '0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      byte_cnt <= '0;
      to_cnt <= '0;
      xor_acc <= '0;
      shadow <= '0;
    end else begin
      state <= state_nx;
      cfg_done <= state == LD_COMMIT;
      cfg_err <= state_nx == LD_ERROR;
      if (state == LD_COMMIT) bitfile_out <= shadow;
      if (cfg_start) begin
        byte_cnt <= '0;
        to_cnt <= '0;
        xor_acc <= '0;
        shadow <= '0;
      end else if (cfg_ready) begin
        to_cnt <= accept ? '0 : (to_cnt == '1 ? to_cnt : to_cnt + 1'b1);
        if (byte_done && state == LD_LOAD) begin
          shadow[byte_cnt*CFG_WORD_W +: CFG_WORD_W] <= byte_val;
          xor_acc <= xor_acc ^ byte_val;
          byte_cnt <= byte_cnt == BCW'(NUM_WORDS - 1) ? byte_cnt : byte_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bitfile_loader.sv
// tb_bitfile_loader: directed frames with a scoreboard of expected committed bitfiles
module tb_bitfile_loader;
  logic clk = 0, rst_n = 0, cfg_start = 0, cfg_bit = 0, cfg_valid = 0;
  logic cfg_ready, cfg_done, cfg_err, busy;
  logic [31:0] bitfile_out;
  logic [31:0] sb[$];
  logic [31:0] exp_bf;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  bitfile_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_bit(cfg_bit), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .bitfile_out(bitfile_out), .cfg_done(cfg_done), .cfg_err(cfg_err), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rst_n && cfg_done) begin
    if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
    else chk("sb_bitfile", bitfile_out, sb.pop_front());
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start();
    cfg_start = 1;
    cfg_valid = 0;
    step();
    cfg_start = 0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      cfg_bit = b[i];
      cfg_valid = 1;
      step();
    end
  endtask
  task automatic idle(input int n);
    cfg_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic expect_commit(input string tag, input logic [31:0] bf);
    cfg_valid = 0;
    chk({tag, "_done_early"}, cfg_done, 0);
    step();
    chk({tag, "_done"}, cfg_done, 1);
    chk({tag, "_bitfile"}, bitfile_out, bf);
    step();
    chk({tag, "_done_once"}, cfg_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, cfg_err, 0);
  endtask
  initial begin
    step();
    step();
    chk("rst_bitfile", bitfile_out, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 0);
    rst_n = 1;
    step();
    // good frame
    start();
    chk("t1_ready", cfg_ready, 1);
    exp_bf = 32'h12FF00EE;
    sb.push_back(exp_bf);
    send_byte(8'hA5); send_byte(8'hEE); send_byte(8'h00);
    send_byte(8'hFF); send_byte(8'h12); send_byte(8'h03);
    expect_commit("t1", exp_bf);
    // bad checksum
    start();
    send_byte(8'hA5); send_byte(8'hEE); send_byte(8'h00);
    send_byte(8'hFF); send_byte(8'h12); send_byte(8'h04);
    cfg_valid = 0;
    chk("t2_err", cfg_err, 1);
    idle(3);
    chk("t2_err_held", cfg_err, 1);
    chk("t2_bitfile", bitfile_out, exp_bf);
    // bad sync
    start();
    chk("t3_err_clr", cfg_err, 0);
    send_byte(8'h5A);
    chk("t3_err", cfg_err, 1);
    chk("t3_ready", cfg_ready, 0);
    chk("t3_busy", busy, 0);
    start();
    chk("t3_restart_err", cfg_err, 0);
    // timeout mid-LOAD
    send_byte(8'hA5); send_byte(8'hEE);
    idle(254);
    chk("t4_no_timeout", cfg_err, 0);
    idle(1);
    chk("t4_timeout", cfg_err, 1);
    start();
    sb.push_back(exp_bf);
    send_byte(8'hA5); send_byte(8'hEE);
    idle(254);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12); send_byte(8'h03);
    expect_commit("t4", exp_bf);
    // abort mid-LOAD, restart with a stray bit in the start cycle
    start();
    send_byte(8'hA5); send_byte(8'hEE);
    cfg_start = 1; cfg_valid = 1; cfg_bit = 1;
    step();
    cfg_start = 0;
    exp_bf = 32'h04030201;
    sb.push_back(exp_bf);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h04);
    expect_commit("t5", exp_bf);
    // reset mid-CHECK
    start();
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    cfg_bit = 0;
    step(); step(); step();
    rst_n = 0;
    step();
    rst_n = 1;
    chk("t6_bitfile", bitfile_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", cfg_ready, 0);
    chk("t6_err", cfg_err, 0);
    chk("t6_done", cfg_done, 0);
    send_byte(8'hA5); send_byte(8'h01);
    chk("t6_ignored_busy", busy, 0);
    chk("t6_ignored_bitfile", bitfile_out, 0);
    start();
    sb.push_back(exp_bf);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h04);
    expect_commit("t6", exp_bf);
    idle(3);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
